fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared FIFO definitions: write-side FSM state encoding, default burst
// length, beat counter width and an index-width helper.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } fifo_state_t;

    localparam int FIFO_BURST_LEN_DEF = 4;

    // Wide enough for the largest legal burst length (15).
    localparam int FIFO_BEAT_W = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: round-robin next-index selection.
// Ports:
//   req       - request vector, one bit per producer
//   last_idx  - index that was served most recently
//   next_idx  - first set request after last_idx, wrapping to 0
//               (holds last_idx when nothing is requesting)
//   any_valid - at least one request bit is set
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [IDX_W-1:0]   next_idx,
    output logic               any_valid
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan offsets 1..NUM_REQ from last_idx; offset NUM_REQ lands back on
    // last_idx itself, so a lone requester can be re-granted.
    always_comb begin
        next_idx = last_idx;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port among NUM_REQ producers using
// round-robin grants of up to BURST_LEN beats (1 beat when the FIFO is at
// or above half full).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   req_valid/data/last - per-producer word stream (data packed DATA_W per producer)
//   req_ready       - per-producer ready, only the granted bit can be set
//   fifo_full       - blocks writes in the same cycle
//   fifo_threshold  - shortens the burst limit to 1
//   wr, data_out    - FIFO write strobe and word (combinational from the grant)
//   grant_id        - currently granted producer
//   busy            - high while a burst is in progress
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | one arbitration cycle; no ready, no write
// ST_BURST | granted producer writes while FIFO not full, until last,
//          | burst limit or withdrawal of valid
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = FIFO_BURST_LEN_DEF,
    parameter int IDX_W     = idx_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    input  logic                      fifo_threshold,
    output logic                      wr,
    output logic [DATA_W-1:0]         data_out,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    localparam logic [FIFO_BEAT_W-1:0] BURST_LIM = FIFO_BEAT_W'(BURST_LEN);

    fifo_state_t            state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [FIFO_BEAT_W-1:0] beat_q, beat_d;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   g_valid;
    logic                   g_last;
    logic [FIFO_BEAT_W-1:0] beat_inc;
    logic [FIFO_BEAT_W-1:0] limit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req       (req_valid),
        .last_idx  (last_q),
        .next_idx  (pick_idx),
        .any_valid (pick_any)
    );

    assign g_valid  = req_valid[grant_q];
    assign g_last   = req_last[grant_q];
    assign beat_inc = beat_q + FIFO_BEAT_W'(1);
    assign limit    = fifo_threshold ? FIFO_BEAT_W'(1) : BURST_LIM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        beat_d    = beat_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any && !fifo_full) begin
                    state_d = ST_BURST;
                    grant_d = pick_idx;
                    beat_d  = '0;
                end
            end
            ST_BURST: begin
                // Full freezes everything; the grant is kept, not revoked.
                if (!fifo_full) begin
                    req_ready[grant_q] = 1'b1;
                    if (!g_valid) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                    end else if (g_last || (beat_inc >= limit)) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Zero-latency write path: full blocks the strobe in the same cycle.
    assign busy     = (state_q == ST_BURST);
    assign wr       = busy && !fifo_full && g_valid;
    assign grant_id = grant_q;

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                data_out = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a transaction-level model predicts
// each cycle's outputs and every write; a negedge monitor compares.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;
    localparam int IDX_W     = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full = 1'b0;
    logic                      fifo_threshold = 1'b0;
    logic                      wr;
    logic [DATA_W-1:0]         data_out;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .fifo_full      (fifo_full),
        .fifo_threshold (fifo_threshold),
        .wr             (wr),
        .data_out       (data_out),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               wr;
        logic               busy;
        logic [NUM_REQ-1:0] ready;
        logic [IDX_W-1:0]   grant;
    } cyc_t;

    typedef struct packed {
        logic [IDX_W-1:0]  id;
        logic [DATA_W-1:0] data;
    } wr_t;

    cyc_t cyc_q[$];
    wr_t  wr_q[$];
    int   obs_grants[$];
    int   obs_beats[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner = producer holding the write port, -1 while arbitrating.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = NUM_REQ - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_obs(input string name, input bit grants, input int i, input int exp);
        int n;
        int v;
        n = grants ? obs_grants.size() : obs_beats.size();
        n_tests++;
        if (i >= n) begin
            n_fail++;
            $display("FAIL %s: entry %0d missing (%0d recorded), expected %0d", name, i, n, exp);
        end else begin
            v = grants ? obs_grants[i] : obs_beats[i];
            if (v != exp) begin
                n_fail++;
                $display("FAIL %s: entry %0d got %0d expected %0d", name, i, v, exp);
            end
        end
    endtask

    task automatic model_step();
        cyc_t c;
        wr_t  w;
        int   lim;
        c = '0;
        if (m_owner < 0) begin
            if (req_valid != '0 && !fifo_full) begin
                for (int k = 1; k <= NUM_REQ && m_owner < 0; k++) begin
                    if (req_valid[(m_last + k) % NUM_REQ]) m_owner = (m_last + k) % NUM_REQ;
                end
                m_beats = 0;
            end
        end else begin
            c.busy  = 1'b1;
            c.grant = IDX_W'(m_owner);
            if (!fifo_full) begin
                c.ready[m_owner] = 1'b1;
                if (!req_valid[m_owner]) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end else begin
                    c.wr   = 1'b1;
                    w.id   = IDX_W'(m_owner);
                    w.data = req_data[m_owner*DATA_W +: DATA_W];
                    wr_q.push_back(w);
                    m_beats++;
                    lim = fifo_threshold ? 1 : BURST_LEN;
                    if (req_last[m_owner] || m_beats >= lim) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end
                end
            end
        end
        cyc_q.push_back(c);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    // Inputs are already set; called at posedge+1, returns at next posedge+1.
    task automatic tick();
        rand_data();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        check("wr_q_drained", wr_q.size(), 0);
        check("cyc_q_drained", cyc_q.size(), 0);
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        fifo_full = 1'b0;
        fifo_threshold = 1'b0;
        cyc_q.delete();
        wr_q.delete();
        m_owner = -1;
        m_beats = 0;
        m_last  = NUM_REQ - 1;
        @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_wr", wr, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant_id, 0);
        rst_n = 1'b1;
        obs_grants.delete();
        obs_beats.delete();
    endtask

    logic prev_busy = 1'b0;
    int   cur_beats = 0;

    always @(negedge clk) begin
        cyc_t e;
        wr_t  w;
        if (rst_n && cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("wr", wr, e.wr);
            check("busy", busy, e.busy);
            check("req_ready", req_ready, e.ready);
            if (e.busy) check("grant_id", grant_id, e.grant);
        end
        if (rst_n && wr) begin
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got wr=1 data %0h expected no write (t=%0t)", data_out, $time);
            end else begin
                w = wr_q.pop_front();
                check("data_out", data_out, w.data);
                check("wr_source", grant_id, w.id);
            end
        end
        if (busy && !prev_busy) begin
            obs_grants.push_back(int'(grant_id));
            cur_beats = 0;
        end
        if (busy && wr) cur_beats++;
        if (!busy && prev_busy) obs_beats.push_back(cur_beats);
        prev_busy = busy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        #1;
        do_reset();

        // Single producer, empty FIFO: grant 0, four beats.
        req_valid = 4'b0001;
        for (int c = 0; c < 12; c++) tick();
        check_obs("single_grant", 1, 0, 0);
        check_obs("single_beats", 0, 0, 4);

        // All requesting, no last: 0,1,2,3,0, four beats each.
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 30; c++) tick();
        for (int i = 0; i < 5; i++) check_obs("rr_order", 1, i, i % NUM_REQ);
        for (int i = 0; i < 4; i++) check_obs("rr_beats", 0, i, 4);

        // Producer 2 with a 3-cycle full stall after two beats.
        do_reset();
        req_valid = 4'b0100;
        for (int k = 0; k < 14; k++) begin
            fifo_full = (k >= 3 && k < 6);
            tick();
        end
        fifo_full = 1'b0;
        check_obs("stall_grant", 1, 0, 2);
        check_obs("stall_beats", 0, 0, 4);

        // Threshold: single-beat grants alternating 1,3,1.
        do_reset();
        req_valid = 4'b1010;
        fifo_threshold = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check_obs("thr_grant0", 1, 0, 1);
        check_obs("thr_grant1", 1, 1, 3);
        check_obs("thr_grant2", 1, 2, 1);
        for (int i = 0; i < 3; i++) check_obs("thr_beats", 0, i, 1);

        // req_last on the second beat.
        do_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            req_last = (m_owner == 0 && m_beats == 1) ? 4'b0001 : 4'b0000;
            tick();
        end
        req_last = '0;
        check_obs("last_beats", 0, 0, 2);

        // Producer 0 withdraws on its first beat; next grant goes to 2.
        do_reset();
        req_valid = 4'b0101;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0101;
        for (int c = 0; c < 6; c++) tick();
        check_obs("withdraw_grant", 1, 0, 0);
        check_obs("withdraw_beats", 0, 0, 0);
        check_obs("withdraw_next", 1, 1, 2);

        // Reset during the third beat of a burst.
        do_reset();
        req_valid = 4'b1111;
        guard = 0;
        while (!(m_owner >= 0 && m_beats == 2) && guard < 20) begin
            tick();
            guard++;
        end
        check("reach_beat3", guard < 20, 1);
        rand_data();
        #1;
        check("wr_before_reset", wr, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_wr", wr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", req_ready, 0);
        @(posedge clk);
        #1;
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) tick();
        check_obs("post_rst_grant", 1, 0, 0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = ($urandom_range(3) != 0);
                req_last[i]  = ($urandom_range(4) == 0);
            end
            fifo_full      = ($urandom_range(6) == 0);
            fifo_threshold = ($urandom_range(3) == 0);
            tick();
        end
        req_valid = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        #1;
        check("final_wr_q_empty", wr_q.size(), 0);
        check("final_cyc_q_empty", cyc_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
